fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_sample_loader_if.sv | 25 ++
 rtl/fft_sample_loader.sv | 92 +++++++++
 tb/tb_fft_sample_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sample_loader_if.sv
// Sample stream, frame handshake and RAM write port of the FFT sample loader.
// The loader uses the slave modport; the sample source / FFT side uses master.
interface fft_sample_loader_if;
    logic [15:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic        FRAME_ACK;
    logic [7:0]  RAM_WADDR;
    logic [15:0] RAM_WDATA;
    logic        RAM_WE;
    logic        FRAME_READY;
    logic [7:0]  SAMPLE_CNT;

    modport master (
        output S_DATA, S_VALID, FRAME_ACK,
        input  S_READY, RAM_WADDR, RAM_WDATA, RAM_WE,
        input  FRAME_READY, SAMPLE_CNT
    );

    modport slave (
        input  S_DATA, S_VALID, FRAME_ACK,
        output S_READY, RAM_WADDR, RAM_WDATA, RAM_WE,
        output FRAME_READY, SAMPLE_CNT
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Loads 256 samples into a 256x16 RAM, then holds the frame until FRAME_ACK.
// Define BIT_REVERSE_EN to write in bit-reversed address order (radix-2 DIT).
module fft_sample_loader (
    input  logic               CLK,
    input  logic               RST,
    fft_sample_loader_if.slave bus
);
    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        FULL
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [7:0]  waddr_map;
    logic        accept;
    logic        we_q;
    logic [7:0]  waddr_q;
    logic [15:0] wdata_q;
    logic        frame_rdy_q;

`ifdef BIT_REVERSE_EN
    always_comb begin
        waddr_map = '0;
        for (int i = 0; i < 8; i++) begin
            waddr_map[i] = cnt[7-i];
        end
    end
`else
    assign waddr_map = cnt;
`endif

    assign accept = (state == FILL) && bus.S_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: begin
                if (accept && (cnt == 8'hFF)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                state_nx = FULL;
            end
            FULL: begin
                if (bus.FRAME_ACK) begin
                    state_nx = FILL;
                end
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    // Counter wraps to 0 on the 256th accept, so a new frame starts at index 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            frame_rdy_q <= 1'b0;
        end else begin
            we_q        <= accept;
            frame_rdy_q <= (state_nx == FULL);
            if (accept) begin
                cnt     <= cnt + 8'd1;
                waddr_q <= waddr_map;
                wdata_q <= bus.S_DATA;
            end
        end
    end

    assign bus.S_READY     = (state == FILL);
    assign bus.RAM_WE      = we_q;
    assign bus.RAM_WADDR   = waddr_q;
    assign bus.RAM_WDATA   = wdata_q;
    assign bus.FRAME_READY = frame_rdy_q;
    assign bus.SAMPLE_CNT  = cnt;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: a reference model queues expected
// RAM writes, a negedge monitor pops and compares them.
module tb_fft_sample_loader;
    logic CLK;
    logic RST;

    fft_sample_loader_if bus();

    fft_sample_loader dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          tag;
        logic [7:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          m_st = 0;
    logic [7:0]  m_idx = '0;
    logic [7:0]  last_a = '0;
    logic [15:0] last_d = '0;
    logic [15:0] mem [256];
    logic [15:0] exp_d [256];

    function automatic logic [7:0] amap(input logic [7:0] i);
        logic [7:0] r;
`ifdef BIT_REVERSE_EN
        for (int b = 0; b < 8; b++) r[b] = i[7-b];
`else
        r = i;
`endif
        return r;
    endfunction

    task automatic chk(input string n, input logic [15:0] act,
                       input logic [15:0] exp);
        ncmp = ncmp + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Reference model: advances on the same edge the DUT samples inputs.
    always @(posedge CLK) begin
        exp_t e;
        cyc = cyc + 1;
        if (RST) begin
            m_st   = 0;
            m_idx  = '0;
            last_a = '0;
            last_d = '0;
        end else begin
            case (m_st)
                0: begin
                    if (bus.S_VALID) begin
                        e.tag = cyc;
                        e.a   = amap(m_idx);
                        e.d   = bus.S_DATA;
                        q.push_back(e);
                        if (m_idx == 8'hFF) m_st = 1;
                        m_idx = m_idx + 8'd1;
                    end
                end
                1: m_st = 2;
                default: if (bus.FRAME_ACK) m_st = 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        chk("s_ready", 16'(bus.S_READY), 16'(m_st == 0));
        chk("frame_ready", 16'(bus.FRAME_READY), 16'(m_st == 2));
        chk("sample_cnt", 16'(bus.SAMPLE_CNT), 16'(m_idx));
        while (q.size() > 0 && q[0].tag < cyc) begin
            e = q.pop_front();
            chk("missed_write", 16'(e.tag), 16'(cyc));
        end
        if (q.size() > 0 && q[0].tag == cyc) begin
            e = q.pop_front();
            chk("ram_we", 16'(bus.RAM_WE), 16'd1);
            chk("ram_waddr", 16'(bus.RAM_WADDR), 16'(e.a));
            chk("ram_wdata", bus.RAM_WDATA, e.d);
            last_a = e.a;
            last_d = e.d;
            if (bus.RAM_WE === 1'b1) mem[bus.RAM_WADDR] = bus.RAM_WDATA;
        end else begin
            chk("ram_we_idle", 16'(bus.RAM_WE), 16'd0);
            chk("waddr_hold", 16'(bus.RAM_WADDR), 16'(last_a));
            chk("wdata_hold", bus.RAM_WDATA, last_d);
        end
    end

    task automatic drv(input logic v, input logic [15:0] d, input logic ack);
        bus.S_VALID   = v;
        bus.S_DATA    = d;
        bus.FRAME_ACK = ack;
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [15:0] base, input logic ack);
        for (int k = 0; k < 256; k++) begin
            exp_d[k] = base + 16'(k);
            drv(1'b1, base + 16'(k), ack);
        end
    endtask

    task automatic frame_end(input string n, input logic ack);
        chk({n, "_flush_fr"}, 16'(bus.FRAME_READY), 16'd0);
        chk({n, "_flush_we"}, 16'(bus.RAM_WE), 16'd1);
        chk({n, "_flush_rdy"}, 16'(bus.S_READY), 16'd0);
        drv(1'b0, 16'h0, ack);
        chk({n, "_full_fr"}, 16'(bus.FRAME_READY), 16'd1);
        chk({n, "_full_we"}, 16'(bus.RAM_WE), 16'd0);
    endtask

    task automatic check_ram(input string n);
        for (int k = 0; k < 256; k++) begin
            chk(n, mem[amap(8'(k))], exp_d[k]);
        end
    endtask

    initial begin
        int n;
        int guard;
        logic v;
        logic [15:0] d;
        RST           = 1'b1;
        bus.S_VALID   = 1'b0;
        bus.S_DATA    = '0;
        bus.FRAME_ACK = 1'b0;
        @(posedge CLK);
        #1;
        drv(1'b1, 16'h5555, 1'b1);
        chk("rst_we", 16'(bus.RAM_WE), 16'd0);
        chk("rst_waddr", 16'(bus.RAM_WADDR), 16'd0);
        chk("rst_wdata", bus.RAM_WDATA, 16'd0);
        chk("rst_cnt", 16'(bus.SAMPLE_CNT), 16'd0);
        chk("rst_fr", 16'(bus.FRAME_READY), 16'd0);
        chk("rst_s_ready", 16'(bus.S_READY), 16'd1);
        RST = 1'b0;

        // Scenario 1: back-to-back frame, data = index
        drv(1'b1, 16'd0, 1'b0);
        chk("first_waddr", 16'(bus.RAM_WADDR), 16'h00);
        chk("first_we", 16'(bus.RAM_WE), 16'd1);
        drv(1'b1, 16'd1, 1'b0);
        chk("second_waddr", 16'(bus.RAM_WADDR), 16'(amap(8'd1)));
        for (int k = 2; k < 256; k++) drv(1'b1, 16'(k), 1'b0);
        for (int k = 0; k < 256; k++) exp_d[k] = 16'(k);
        frame_end("s1", 1'b0);
        check_ram("s1_ram");

        // Scenario 2: FULL ignores samples
        for (int k = 0; k < 10; k++) begin
            drv(1'b1, 16'hDEAD, 1'b0);
        end
        chk("s2_full_we", 16'(bus.RAM_WE), 16'd0);
        check_ram("s2_ram");

        // Scenario 3: release frame, next write hits index 0
        drv(1'b0, 16'h0, 1'b1);
        chk("s3_fr", 16'(bus.FRAME_READY), 16'd0);
        chk("s3_rdy", 16'(bus.S_READY), 16'd1);
        chk("s3_cnt", 16'(bus.SAMPLE_CNT), 16'd0);
        drv(1'b1, 16'h1234, 1'b0);
        chk("s3_waddr", 16'(bus.RAM_WADDR), 16'h00);
        chk("s3_wdata", bus.RAM_WDATA, 16'h1234);

        // Scenario 4: reset after 100 accepts, then a full frame
        for (int k = 1; k < 100; k++) drv(1'b1, 16'(k), 1'b0);
        chk("s4_cnt_pre", 16'(bus.SAMPLE_CNT), 16'd100);
        RST = 1'b1;
        drv(1'b1, 16'hBEEF, 1'b1);
        RST = 1'b0;
        chk("s4_cnt", 16'(bus.SAMPLE_CNT), 16'd0);
        chk("s4_we", 16'(bus.RAM_WE), 16'd0);
        chk("s4_rdy", 16'(bus.S_READY), 16'd1);
        fill(16'h4000, 1'b0);
        frame_end("s4", 1'b0);
        check_ram("s4_ram");
        drv(1'b0, 16'h0, 1'b1);

        // Scenario 5: ~50% valid duty with varied data
        n = 0;
        guard = 0;
        while (n < 256 && guard < 4000) begin
            v = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (v) begin
                exp_d[n] = d;
                n = n + 1;
            end
            drv(v, d, 1'b0);
            guard = guard + 1;
        end
        chk("s5_accepts", 16'(n), 16'd256);
        frame_end("s5", 1'b0);
        check_ram("s5_ram");
        drv(1'b0, 16'h0, 1'b1);

        // Scenario 6: FRAME_ACK held through FILL and FLUSH
        fill(16'h8800, 1'b1);
        frame_end("s6", 1'b1);
        bus.FRAME_ACK = 1'b0;
        drv(1'b0, 16'h0, 1'b0);
        chk("s6_fr_hold", 16'(bus.FRAME_READY), 16'd1);
        check_ram("s6_ram");

        drv(1'b0, 16'h0, 1'b0);
        drv(1'b0, 16'h0, 1'b0);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
